// File: rtl/apb_timer.sv
// APB timer: 32-bit down-counter behind a 16-bit prescaler, one-shot or periodic, level IRQ.
// Optional compare register and CMPF flag are built when APB_TIMER_CMP_EN is defined.
module apb_timer #(
    parameter int ADDR_W = 5
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ
);

    localparam logic [ADDR_W-3:0] OFF_CTRL   = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] OFF_PRESC  = (ADDR_W-2)'(1);
    localparam logic [ADDR_W-3:0] OFF_LOAD   = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] OFF_COUNT  = (ADDR_W-2)'(3);
    localparam logic [ADDR_W-3:0] OFF_STATUS = (ADDR_W-2)'(4);
    localparam logic [ADDR_W-3:0] OFF_CMP    = (ADDR_W-2)'(5);

    logic [ADDR_W-3:0] offset;
    logic              wr;
    logic              mapped;
    logic              ctrl_en;
    logic              ctrl_periodic;
    logic              ctrl_irq_en;
    logic [15:0]       prescale;
    logic [31:0]       load_val;
    logic [31:0]       count;
    logic [15:0]       pcnt;
    logic              tof;
    logic              tick;
    logic              en_rise;
    logic              underflow;
    logic [31:0]       count_nxt;
    logic              tof_nxt;
    logic              irq_en_nxt;
    logic              irq_nxt;
    logic              unused_paddr;

    assign offset       = PADDR[ADDR_W-1:2];
    assign unused_paddr = ^{PADDR[31:ADDR_W], PADDR[1:0]};
    assign wr           = PSEL & PENABLE & PWRITE;
    assign tick         = ctrl_en & (pcnt == prescale);
    assign en_rise      = wr & (offset == OFF_CTRL) & PWDATA[0] & ~ctrl_en;
    assign underflow    = tick & (count == 32'd0);
    assign irq_en_nxt   = (wr && offset == OFF_CTRL) ? PWDATA[2] : ctrl_irq_en;
    assign tof_nxt      = underflow | (tof & ~(wr & (offset == OFF_STATUS) & PWDATA[0]));

`ifdef APB_TIMER_CMP_EN
    logic [31:0] cmp_val;
    logic        cmpf;
    logic        cmpf_nxt;

    // Compare uses the post-update count, so a COUNT write on a tick can also hit.
    assign cmpf_nxt = (tick & (count_nxt == cmp_val))
                    | (cmpf & ~(wr & (offset == OFF_STATUS) & PWDATA[1]));
    assign irq_nxt  = irq_en_nxt & (tof_nxt | cmpf_nxt);
    assign mapped   = (offset <= OFF_CMP);
`else
    assign irq_nxt  = irq_en_nxt & tof_nxt;
    assign mapped   = (offset <= OFF_STATUS);
`endif

    // Priority: EN rising reload, then software COUNT write, then tick.
    always_comb begin
        count_nxt = count;
        if (en_rise) begin
            count_nxt = load_val;
        end else if (wr && offset == OFF_COUNT) begin
            count_nxt = PWDATA;
        end else if (tick) begin
            if (count != 32'd0) begin
                count_nxt = count - 32'd1;
            end else if (ctrl_periodic) begin
                count_nxt = load_val;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            prescale      <= 16'd0;
            load_val      <= 32'd0;
            count         <= 32'd0;
            pcnt          <= 16'd0;
            tof           <= 1'b0;
            IRQ           <= 1'b0;
        end else begin
            count       <= count_nxt;
            tof         <= tof_nxt;
            IRQ         <= irq_nxt;
            ctrl_irq_en <= irq_en_nxt;
            if (wr && offset == OFF_CTRL) begin
                ctrl_en       <= PWDATA[0];
                ctrl_periodic <= PWDATA[1];
            end else if (underflow && !ctrl_periodic) begin
                ctrl_en <= 1'b0;
            end
            if (wr && offset == OFF_PRESC) begin
                prescale <= PWDATA[15:0];
            end
            if (wr && offset == OFF_LOAD) begin
                load_val <= PWDATA;
            end
            if (en_rise) begin
                pcnt <= 16'd0;
            end else if (ctrl_en) begin
                pcnt <= tick ? 16'd0 : pcnt + 16'd1;
            end
        end
    end

`ifdef APB_TIMER_CMP_EN
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cmp_val <= 32'd0;
            cmpf    <= 1'b0;
        end else begin
            cmpf <= cmpf_nxt;
            if (wr && offset == OFF_CMP) begin
                cmp_val <= PWDATA;
            end
        end
    end
`endif

    always_comb begin
        PRDATA = 32'd0;
        if (PSEL && !PWRITE) begin
            case (offset)
                OFF_CTRL:   PRDATA = {29'd0, ctrl_irq_en, ctrl_periodic, ctrl_en};
                OFF_PRESC:  PRDATA = {16'd0, prescale};
                OFF_LOAD:   PRDATA = load_val;
                OFF_COUNT:  PRDATA = count;
`ifdef APB_TIMER_CMP_EN
                OFF_STATUS: PRDATA = {30'd0, cmpf, tof};
                OFF_CMP:    PRDATA = cmp_val;
`else
                OFF_STATUS: PRDATA = {31'd0, tof};
`endif
                default:    PRDATA = 32'd0;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & ~mapped;

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: reads push expected values to a scoreboard, a monitor checks each access phase.
module tb_apb_timer;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        IRQ;

    always #5 PCLK = ~PCLK;

    apb_timer dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .IRQ(IRQ)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        logic        chk_irq;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESET && PSEL && PENABLE && !PWRITE) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: read of %h with empty scoreboard", PADDR);
            end else begin
                e = sb.pop_front();
                if (PRDATA !== e.data) begin
                    errors++;
                    $display("FAIL %s prdata: got %h expected %h", e.name, PRDATA, e.data);
                end
                checks++;
                if (PSLVERR !== e.err) begin
                    errors++;
                    $display("FAIL %s pslverr: got %b expected %b", e.name, PSLVERR, e.err);
                end
                if (PREADY !== 1'b1) begin
                    errors++;
                    $display("FAIL %s pready: got %b expected 1", e.name, PREADY);
                end
                if (e.chk_irq) begin
                    checks++;
                    if (IRQ !== e.irq) begin
                        errors++;
                        $display("FAIL %s irq: got %b expected %b", e.name, IRQ, e.irq);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Called 1 time unit after an edge; setup phase is the current cycle.
    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp,
                      input logic exp_err = 1'b0, input logic chk_irq = 1'b0,
                      input logic exp_irq = 1'b0);
        exp_t e;
        e.name = name; e.data = exp; e.err = exp_err; e.chk_irq = chk_irq; e.irq = exp_irq;
        sb.push_back(e);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0;
        idle(3);
        PRESET = 1'b0;

        // Reset state.
        rd("rst_ctrl",   32'h00, 32'd0, 1'b0, 1'b1, 1'b0);
        rd("rst_presc",  32'h04, 32'd0);
        rd("rst_load",   32'h08, 32'd0);
        rd("rst_count",  32'h0C, 32'd0);
        rd("rst_status", 32'h10, 32'd0, 1'b0, 1'b1, 1'b0);
`ifdef APB_TIMER_CMP_EN
        rd("rst_cmp",    32'h14, 32'd0);
        wr(32'h14, 32'hFFFF_FFFF);
`endif

        // Periodic, PRESCALE=3, LOAD=4: EN edge E0, ticks every 4 cycles, TOF at E20, E40, E60.
        wr(32'h04, 32'd3);
        wr(32'h08, 32'd4);
        wr(32'h00, 32'h7);
        rd("per_cnt4", 32'h0C, 32'd4);
        idle(3);
        rd("per_cnt3", 32'h0C, 32'd3);
        idle(3);
        rd("per_cnt2", 32'h0C, 32'd2);
        rd("per_cnt1", 32'h0C, 32'd1);
        idle(2);
        rd("per_cnt0", 32'h0C, 32'd0);
        rd("per_pre_tof1", 32'h10, 32'd0, 1'b0, 1'b1, 1'b0);
        rd("per_tof1",     32'h10, 32'd1, 1'b0, 1'b1, 1'b1);
        wr(32'h10, 32'd1);
        rd("per_clr1",     32'h10, 32'd0, 1'b0, 1'b1, 1'b0);
        idle(12);
        rd("per_pre_tof2", 32'h10, 32'd0, 1'b0, 1'b1, 1'b0);
        rd("per_tof2",     32'h10, 32'd1, 1'b0, 1'b1, 1'b1);
        wr(32'h10, 32'd1);
        idle(14);
        wr(32'h10, 32'd1);
        rd("w1c_set_wins", 32'h10, 32'd1, 1'b0, 1'b1, 1'b1);
        wr(32'h10, 32'd1);
        rd("w1c_clear",    32'h10, 32'd0, 1'b0, 1'b1, 1'b0);
        wr(32'h00, 32'h0);
        rd("freeze_a", 32'h0C, 32'd2);
        idle(10);
        rd("freeze_b", 32'h0C, 32'd2);

        // COUNT write lands on a tick edge (PRESCALE=7, tick applied at E8).
        wr(32'h04, 32'd7);
        wr(32'h08, 32'd100);
        wr(32'h00, 32'h1);
        idle(6);
        wr(32'h0C, 32'h10);
        rd("cnt_wr_wins", 32'h0C, 32'h10);
        wr(32'h00, 32'h0);

        // One-shot, PRESCALE=0, LOAD=2: TOF at E3, EN self-clears.
        wr(32'h04, 32'd0);
        wr(32'h08, 32'd2);
        wr(32'h00, 32'h5);
        idle(1);
        rd("os_pre_tof", 32'h10, 32'd0, 1'b0, 1'b1, 1'b0);
        rd("os_tof",     32'h10, 32'd1, 1'b0, 1'b1, 1'b1);
        rd("os_ctrl",    32'h00, 32'h4);
        rd("os_count",   32'h0C, 32'd0);
        idle(4);
        rd("os_count_hold", 32'h0C, 32'd0);
        wr(32'h10, 32'd1);

        // Unmapped offsets.
        rd("unmapped_18", 32'h18, 32'd0, 1'b1);
        rd("unmapped_1c", 32'h1C, 32'd0, 1'b1);
`ifdef APB_TIMER_CMP_EN
        wr(32'h08, 32'd10);
        wr(32'h14, 32'd5);
        wr(32'h04, 32'd0);
        wr(32'h00, 32'h5);
        idle(3);
        rd("cmp_pre", 32'h10, 32'd0, 1'b0, 1'b1, 1'b0);
        rd("cmpf",    32'h10, 32'd2, 1'b0, 1'b1, 1'b1);
        rd("cmp_reg", 32'h14, 32'd5);
`else
        rd("unmapped_14", 32'h14, 32'd0, 1'b1);
`endif

        // Reset while running with an interrupt pending.
        wr(32'h10, 32'd3);
        wr(32'h04, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h00, 32'h7);
        idle(2);
        rd("pre_reset_tof", 32'h10, 32'd1, 1'b0, 1'b1, 1'b1);
        PRESET = 1'b1;
        idle(1);
        PRESET = 1'b0;
        rd("post_reset_status", 32'h10, 32'd0, 1'b0, 1'b1, 1'b0);
        rd("post_reset_ctrl",   32'h00, 32'd0, 1'b0, 1'b1, 1'b0);
        rd("post_reset_presc",  32'h04, 32'd0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge PCLK);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
